id_stage: RTL

- Instruction-decode stage of the 5-stage MIPS32 pipeline, between the IF/ID register and the EX stage.
- Decodes the incoming instruction and drives both register-file read ports.
- Forwards results from the EX and MEM stages, detects load-use hazards, and holds the ID/EX pipeline register that feeds EX.

---
 rtl/id_stage_pkg.sv | 88 ++++++++
 rtl/id_decode.sv | 115 +++++++++++
 rtl/id_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared decode constants, ID/EX register layout and operand-select helper
package id_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int InstBus    = 32;
    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [AluOpBus-1:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [AluOpBus-1:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [AluOpBus-1:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [AluOpBus-1:0] EXE_LW_OP   = 8'b1110_0011;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP        = 3'b000;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [AluSelBus-1:0] EXE_RES_ARITHMETIC = 3'b100;
    localparam logic [AluSelBus-1:0] EXE_RES_LOAD_STORE = 3'b111;

    typedef struct packed {
        logic                  valid;
        logic [RegBus-1:0]     pc;
        logic [AluOpBus-1:0]   aluop;
        logic [AluSelBus-1:0]  alusel;
        logic [RegBus-1:0]     reg1;
        logic [RegBus-1:0]     reg2;
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic                  illegal;
    } idex_t;

    // Youngest producer wins: EX result is newer than MEM result.
    function automatic logic [RegBus-1:0] resolve_operand(
        input logic                  rd_en,
        input logic [RegAddrBus-1:0] addr,
        input logic [RegBus-1:0]     imm,
        input logic                  ex_wreg,
        input logic [RegAddrBus-1:0] ex_wd,
        input logic [RegBus-1:0]     ex_wdata,
        input logic                  mem_wreg,
        input logic [RegAddrBus-1:0] mem_wd,
        input logic [RegBus-1:0]     mem_wdata,
        input logic [RegBus-1:0]     rf_data
    );
        if (!rd_en)
            return imm;
        else if (addr == '0)
            return ZeroWord;
        else if (ex_wreg && ex_wd == addr)
            return ex_wdata;
        else if (mem_wreg && mem_wd == addr)
            return mem_wdata;
        else
            return rf_data;
    endfunction

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational MIPS32 instruction decoder for the ID stage
module id_decode
    import id_stage_pkg::*;
(
    input  logic [InstBus-1:0]    inst,
    output logic                  reg1_read,
    output logic                  reg2_read,
    output logic [RegAddrBus-1:0] reg1_addr,
    output logic [RegAddrBus-1:0] reg2_addr,
    output logic [RegBus-1:0]     imm,
    output logic [AluOpBus-1:0]   aluop,
    output logic [AluSelBus-1:0]  alusel,
    output logic [RegAddrBus-1:0] wd,
    output logic                  wreg,
    output logic                  illegal
);

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign shamt = inst[10:6];
    assign funct = inst[5:0];
    assign imm16 = inst[15:0];

    always_comb begin
        reg1_read = 1'b0;
        reg2_read = 1'b0;
        reg1_addr = '0;
        reg2_addr = '0;
        imm       = ZeroWord;
        aluop     = EXE_NOP_OP;
        alusel    = EXE_RES_NOP;
        wd        = '0;
        wreg      = 1'b0;
        illegal   = 1'b1;

        case (op)
            OP_SPECIAL: begin
                illegal = 1'b0;
                case (funct)
                    FN_ADDU: begin aluop = EXE_ADDU_OP; alusel = EXE_RES_ARITHMETIC; end
                    FN_SUBU: begin aluop = EXE_SUBU_OP; alusel = EXE_RES_ARITHMETIC; end
                    FN_SLT:  begin aluop = EXE_SLT_OP;  alusel = EXE_RES_ARITHMETIC; end
                    FN_AND:  begin aluop = EXE_AND_OP;  alusel = EXE_RES_LOGIC;      end
                    FN_OR:   begin aluop = EXE_OR_OP;   alusel = EXE_RES_LOGIC;      end
                    FN_XOR:  begin aluop = EXE_XOR_OP;  alusel = EXE_RES_LOGIC;      end
                    FN_NOR:  begin aluop = EXE_NOR_OP;  alusel = EXE_RES_LOGIC;      end
                    FN_SLL:  begin aluop = EXE_SLL_OP;  alusel = EXE_RES_SHIFT;      end
                    FN_SRL:  begin aluop = EXE_SRL_OP;  alusel = EXE_RES_SHIFT;      end
                    FN_SRA:  begin aluop = EXE_SRA_OP;  alusel = EXE_RES_SHIFT;      end
                    default: illegal = 1'b1;
                endcase
                if (!illegal) begin
                    wd        = rd;
                    wreg      = 1'b1;
                    reg2_read = 1'b1;
                    reg2_addr = rt;
                    // Shifts take shamt through the unread port-1 path.
                    if (alusel == EXE_RES_SHIFT) begin
                        imm = {27'd0, shamt};
                    end else begin
                        reg1_read = 1'b1;
                        reg1_addr = rs;
                    end
                end
            end
            OP_ADDIU, OP_SLTI, OP_LW: begin
                illegal = 1'b0;
                imm     = {{16{imm16[15]}}, imm16};
                case (op)
                    OP_ADDIU: begin aluop = EXE_ADDU_OP; alusel = EXE_RES_ARITHMETIC; end
                    OP_SLTI:  begin aluop = EXE_SLT_OP;  alusel = EXE_RES_ARITHMETIC; end
                    default:  begin aluop = EXE_LW_OP;   alusel = EXE_RES_LOAD_STORE; end
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                illegal = 1'b0;
                imm     = {16'h0, imm16};
                alusel  = EXE_RES_LOGIC;
                case (op)
                    OP_ANDI: aluop = EXE_AND_OP;
                    OP_ORI:  aluop = EXE_OR_OP;
                    default: aluop = EXE_XOR_OP;
                endcase
            end
            OP_LUI: begin
                illegal = 1'b0;
                imm     = {imm16, 16'h0};
                aluop   = EXE_OR_OP;
                alusel  = EXE_RES_LOGIC;
            end
            default: ;
        endcase

        if (!illegal && op != OP_SPECIAL) begin
            reg1_read = 1'b1;
            reg1_addr = rs;
            wd        = rt;
            wreg      = 1'b1;
        end

        if (wd == '0)
            wreg = 1'b0;
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS32 ID stage: decode, forwarding, load-use hazard and ID/EX register
// Optional: ID_STALL_CNT_EN adds stall_cnt_o, a saturating count of load-use bubbles.
module id_stage
    import id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid_i,
    input  logic [RegBus-1:0]     pc_i,
    input  logic [InstBus-1:0]    inst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  reg1_read_o,
    output logic                  reg2_read_o,
    output logic [RegAddrBus-1:0] reg1_addr_o,
    output logic [RegAddrBus-1:0] reg2_addr_o,
    input  logic [RegBus-1:0]     reg1_data_i,
    input  logic [RegBus-1:0]     reg2_data_i,
    input  logic                  ex_wreg_i,
    input  logic [RegAddrBus-1:0] ex_wd_i,
    input  logic [RegBus-1:0]     ex_wdata_i,
    input  logic                  ex_is_load_i,
    input  logic                  mem_wreg_i,
    input  logic [RegAddrBus-1:0] mem_wd_i,
    input  logic [RegBus-1:0]     mem_wdata_i,
    output logic                  stallreq_o,
    output logic                  ex_valid_o,
    output logic [RegBus-1:0]     ex_pc_o,
    output logic [AluOpBus-1:0]   ex_aluop_o,
    output logic [AluSelBus-1:0]  ex_alusel_o,
    output logic [RegBus-1:0]     ex_reg1_o,
    output logic [RegBus-1:0]     ex_reg2_o,
    output logic [RegAddrBus-1:0] ex_wd_o,
    output logic                  ex_wreg_o,
    output logic                  ex_illegal_o
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    localparam idex_t BUBBLE = '{
        valid:   1'b0,
        pc:      RESET_PC,
        aluop:   EXE_NOP_OP,
        alusel:  EXE_RES_NOP,
        reg1:    ZeroWord,
        reg2:    ZeroWord,
        wd:      '0,
        wreg:    1'b0,
        illegal: 1'b0
    };

    logic [RegBus-1:0]     imm;
    logic [AluOpBus-1:0]   aluop;
    logic [AluSelBus-1:0]  alusel;
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic                  illegal;
    logic [RegBus-1:0]     reg1_val;
    logic [RegBus-1:0]     reg2_val;
    logic                  load_dep;
    idex_t                 idex;

    id_decode u_decode (
        .inst      (inst_i),
        .reg1_read (reg1_read_o),
        .reg2_read (reg2_read_o),
        .reg1_addr (reg1_addr_o),
        .reg2_addr (reg2_addr_o),
        .imm       (imm),
        .aluop     (aluop),
        .alusel    (alusel),
        .wd        (wd),
        .wreg      (wreg),
        .illegal   (illegal)
    );

    assign reg1_val = resolve_operand(reg1_read_o, reg1_addr_o, imm,
                                      ex_wreg_i, ex_wd_i, ex_wdata_i,
                                      mem_wreg_i, mem_wd_i, mem_wdata_i, reg1_data_i);
    assign reg2_val = resolve_operand(reg2_read_o, reg2_addr_o, imm,
                                      ex_wreg_i, ex_wd_i, ex_wdata_i,
                                      mem_wreg_i, mem_wd_i, mem_wdata_i, reg2_data_i);

    // A load in EX has no data yet; its consumer must wait one cycle for MEM forwarding.
    assign load_dep = (reg1_read_o && reg1_addr_o == ex_wd_i) ||
                      (reg2_read_o && reg2_addr_o == ex_wd_i);
    assign stallreq_o = inst_valid_i && ex_is_load_i && ex_wreg_i &&
                        (ex_wd_i != '0) && load_dep && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex <= BUBBLE;
        end else if (flush_i) begin
            idex <= BUBBLE;
        end else if (stall_i) begin
            idex <= idex;
        end else if (stallreq_o || !inst_valid_i) begin
            idex <= BUBBLE;
        end else begin
            idex.valid   <= 1'b1;
            idex.pc      <= pc_i;
            idex.aluop   <= aluop;
            idex.alusel  <= alusel;
            idex.reg1    <= reg1_val;
            idex.reg2    <= reg2_val;
            idex.wd      <= wd;
            idex.wreg    <= wreg;
            idex.illegal <= illegal;
        end
    end

    assign ex_valid_o   = idex.valid;
    assign ex_pc_o      = idex.pc;
    assign ex_aluop_o   = idex.aluop;
    assign ex_alusel_o  = idex.alusel;
    assign ex_reg1_o    = idex.reg1;
    assign ex_reg2_o    = idex.reg2;
    assign ex_wd_o      = idex.wd;
    assign ex_wreg_o    = idex.wreg;
    assign ex_illegal_o = idex.illegal;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stallreq_o && !stall_i && !flush_i && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule
